texture_quad_buffer: RTL
========================

# texture_quad_buffer

Texture memory that serves the texel-quad requests of the texture mapping unit. It answers four independent texel addresses per cycle with registered texel data, one cycle after the addresses are presented. It is loaded from the command stream through an AXI-Stream slave, which packs `CMD_STREAM_WIDTH` beats into `PIXEL_WIDTH` texel words. It sits between the command parser (write side) and the TMU sampler (read side).

## Interface
Parameters:
- `CMD_STREAM_WIDTH`, 64: stream beat width. Must be a multiple of `PIXEL_WIDTH`.
- `SUB_PIXEL_WIDTH`, 8: bits per colour channel.
- `PIXEL_WIDTH`, localparam `4 * SUB_PIXEL_WIDTH`: texel word width.
- `ADDR_WIDTH`, 17: texel word address width.
- `LANES`, localparam `CMD_STREAM_WIDTH / PIXEL_WIDTH`: texel words per beat.

Ports:
- `aclk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in 1: load beat valid.
- `s_axis_tready` out 1: load beat accepted when high together with valid.
- `s_axis_tlast` in 1: last beat of a texture upload.
- `s_axis_tdata` in `CMD_STREAM_WIDTH`: texel words; lane 0 sits in the LSBs and goes to the lowest address.
- `swapBuffer` in 1: single-cycle request to exchange front and back page. Used only with the macro.
- `loadBusy` out 1: an upload is in progress.
- `texelAddr00`, `texelAddr01`, `texelAddr10`, `texelAddr11` in `ADDR_WIDTH` each: quad read addresses.
- `texelOutput00`, `texelOutput01`, `texelOutput10`, `texelOutput11` out `PIXEL_WIDTH` each: quad read data.

## Operation
Storage:
- Four replicated RAM copies, one per quad port. Each copy is `2^ADDR_WIDTH / LANES` entries of `CMD_STREAM_WIDTH`.
- A write goes to all four copies.
- A read selects the entry with `addr[ADDR_WIDTH-1:log2(LANES)]`, then the lane with `addr[log2(LANES)-1:0]`. The lane select is registered with the RAM read.

Load FSM:
- IDLE:
  - `s_axis_tready`=1, `loadBusy`=0, beat counter=0.
  - An accepted beat writes entry 0 and moves to LOAD, or stays in IDLE if `tlast` is set.
- LOAD:
  - `s_axis_tready`=1, `loadBusy`=1.
  - Each accepted beat writes entry `counter`, then increments the counter.
  - An accepted beat with `tlast` returns to IDLE and clears the counter.
- The counter wraps to 0 after the last entry; the following beats overwrite from the start.
- `tvalid` low stalls the FSM with no state change.

Read/write collision on the same entry in the same cycle: the read returns the old data.

Reads never stall and are independent of load state.

## Timing
- Read latency: exactly 1 cycle. Addresses at edge N produce data valid after edge N+1. Fully pipelined, one quad per cycle.
- Write visibility: a beat accepted at edge N is readable by addresses presented at edge N+1.
- `loadBusy` rises the cycle after the first accepted beat of a multi-beat upload. It falls the cycle after the `tlast` beat is accepted.
- Reset values: `texelOutput*`=0, `s_axis_tready`=1, `loadBusy`=0, FSM=IDLE, counter=0, front page=0.
- RAM contents are not reset.
- Reset asserted mid-upload: the FSM returns to IDLE immediately. Partially written data remains. The next beat starts at entry 0.

## Configuration
`TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN`

Defined:
- RAM depth doubles; the page bit is the address MSB.
- Loads write the back page (`~front`); reads use the front page.
- `swapBuffer` in IDLE toggles `front` at the next edge.
- `swapBuffer` in LOAD sets a pending flag and the FSM enters state SWAP_PEND after `tlast`.
- SWAP_PEND: `s_axis_tready`=0, `loadBusy`=1. Toggles `front` and returns to IDLE after one cycle.
- Repeated `swapBuffer` pulses while a swap is pending collapse into one swap.

Undefined:
- Single page; `swapBuffer` is ignored.
- SWAP_PEND does not exist.
- Readers observe a load in progress.

## Test plan
- Reset, then upload one 2-beat packet with data {0x22222222_11111111, 0x44444444_33333333}. Read addresses 0,1,2,3 on 00..11 -> outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 one cycle later.
- Back-to-back reads of addresses 3,2,1,0 on port 00 on consecutive cycles -> data 0x44444444, 0x33333333, 0x22222222, 0x11111111 on consecutive cycles. No bubbles.
- `tvalid` toggled every other cycle on a 4-beat packet -> exactly 4 writes to entries 0..3. `loadBusy` is high from cycle 2 until one cycle after the `tlast` acceptance.
- Read address 4 while writing entry 2 (addresses 4/5) with 0xBBBBBBBB_AAAAAAAA -> old value the same cycle, 0xAAAAAAAA the next read.
- Assert `resetn`=0 mid-packet, release, send 1 beat 0x…_DEADBEEF -> address 0 reads 0xDEADBEEF. Outputs are 0 during reset.
- With the macro: pulse `swapBuffer` mid-load -> `tready`=0 for one cycle after `tlast`. Front-page reads show the old data before the swap and the new data after.

Source files
------------

// File: rtl/texture_quad_buffer.sv
// Quad-ported texel memory: four replicated RAM copies loaded from an AXI-Stream slave.
// Optional front/back paging is enabled by defining TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN.
module texture_quad_buffer #(
    parameter int CMD_STREAM_WIDTH = 64,
    parameter int SUB_PIXEL_WIDTH  = 8,
    parameter int ADDR_WIDTH       = 17,
    localparam int PIXEL_WIDTH     = 4 * SUB_PIXEL_WIDTH,
    localparam int LANES           = CMD_STREAM_WIDTH / PIXEL_WIDTH
) (
    input  logic                        aclk,
    input  logic                        resetn,

    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s_axis_tdata,

    input  logic                        swapBuffer,
    output logic                        loadBusy,

    input  logic [ADDR_WIDTH-1:0]       texelAddr00,
    input  logic [ADDR_WIDTH-1:0]       texelAddr01,
    input  logic [ADDR_WIDTH-1:0]       texelAddr10,
    input  logic [ADDR_WIDTH-1:0]       texelAddr11,
    output logic [PIXEL_WIDTH-1:0]      texelOutput00,
    output logic [PIXEL_WIDTH-1:0]      texelOutput01,
    output logic [PIXEL_WIDTH-1:0]      texelOutput10,
    output logic [PIXEL_WIDTH-1:0]      texelOutput11
);

    localparam int LANE_BITS  = $clog2(LANES);
    localparam int LANE_W     = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int ENTRY_BITS = ADDR_WIDTH - LANE_BITS;
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
    localparam int RAM_ABITS  = ENTRY_BITS + 1;
`else
    localparam int RAM_ABITS  = ENTRY_BITS;
`endif
    localparam int RAM_DEPTH  = 1 << RAM_ABITS;

    if ((CMD_STREAM_WIDTH % PIXEL_WIDTH) != 0) begin : g_width_check
        $error("CMD_STREAM_WIDTH must be a multiple of PIXEL_WIDTH");
    end

`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SWAP_PEND} state_t;
`else
    typedef enum logic {ST_IDLE, ST_LOAD} state_t;
`endif

    state_t                  state_reg, state_next;
    logic [ENTRY_BITS-1:0]   count_reg, count_next;
    logic                    rd_valid_reg;
    logic                    write_en;
    logic                    beat_accept;
    logic [RAM_ABITS-1:0]    wr_addr;

`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
    logic                    front_reg, front_next;
    logic                    swap_pend_reg, swap_pend_next;
`else
    logic                    unused_swap;
    assign unused_swap = swapBuffer;
`endif

    assign beat_accept = s_axis_tvalid & s_axis_tready;

    // ---------------------------------------------------------------
    // Load FSM
    // ---------------------------------------------------------------
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            rd_valid_reg  <= 1'b0;
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
            front_reg     <= 1'b0;
            swap_pend_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rd_valid_reg  <= 1'b1;
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
            front_reg     <= front_next;
            swap_pend_reg <= swap_pend_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        s_axis_tready  = 1'b1;
        loadBusy       = 1'b0;
        write_en       = 1'b0;
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
        front_next     = front_reg;
        swap_pend_next = swap_pend_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
                if (swapBuffer) begin
                    front_next = ~front_reg;
                end
`endif
                if (beat_accept) begin
                    write_en = 1'b1;
                    if (!s_axis_tlast) begin
                        state_next = ST_LOAD;
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                loadBusy = 1'b1;
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
                if (swapBuffer) begin
                    swap_pend_next = 1'b1;
                end
`endif
                if (beat_accept) begin
                    write_en = 1'b1;
                    if (s_axis_tlast) begin
                        count_next = '0;
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
                        state_next = (swap_pend_reg || swapBuffer) ? ST_SWAP_PEND : ST_IDLE;
`else
                        state_next = ST_IDLE;
`endif
                    end else begin
                        // Natural wrap overwrites from entry 0 on oversize uploads
                        count_next = count_reg + 1'b1;
                    end
                end
            end
`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
            ST_SWAP_PEND: begin
                s_axis_tready  = 1'b0;
                loadBusy       = 1'b1;
                front_next     = ~front_reg;
                swap_pend_next = 1'b0;
                state_next     = ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
    assign wr_addr = {~front_reg, count_reg};
`else
    assign wr_addr = count_reg;
`endif

    // ---------------------------------------------------------------
    // Replicated read ports
    // ---------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  quad_addr [4];
    logic [PIXEL_WIDTH-1:0] quad_data [4];

    assign quad_addr[0] = texelAddr00;
    assign quad_addr[1] = texelAddr01;
    assign quad_addr[2] = texelAddr10;
    assign quad_addr[3] = texelAddr11;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_copy
        logic [CMD_STREAM_WIDTH-1:0]          mem [RAM_DEPTH];
        logic [CMD_STREAM_WIDTH-1:0]          rd_word_reg;
        logic [LANES-1:0][PIXEL_WIDTH-1:0]    rd_lanes;
        logic [RAM_ABITS-1:0]                 rd_addr;
        logic [LANE_W-1:0]                    rd_lane;
        logic [LANE_W-1:0]                    lane_reg;

`ifdef TEXTURE_QUAD_BUFFER_DOUBLE_BUFFER_EN
        assign rd_addr = {front_reg, quad_addr[gi][ADDR_WIDTH-1:LANE_BITS]};
`else
        assign rd_addr = quad_addr[gi][ADDR_WIDTH-1:LANE_BITS];
`endif

        if (LANE_BITS > 0) begin : g_lane
            assign rd_lane = quad_addr[gi][LANE_W-1:0];
        end else begin : g_nolane
            assign rd_lane = '0;
        end

        // Read-before-write: a same-entry collision returns the old word
        always_ff @(posedge aclk) begin
            if (write_en) begin
                mem[wr_addr] <= s_axis_tdata;
            end
            rd_word_reg <= mem[rd_addr];
        end

        always_ff @(posedge aclk or negedge resetn) begin
            if (!resetn) begin
                lane_reg <= '0;
            end else begin
                lane_reg <= rd_lane;
            end
        end

        // The RAM output register has no reset, so outputs are gated until the first post-reset read
        assign rd_lanes      = rd_word_reg;
        assign quad_data[gi] = rd_valid_reg ? rd_lanes[lane_reg] : '0;
    end

    assign texelOutput00 = quad_data[0];
    assign texelOutput01 = quad_data[1];
    assign texelOutput10 = quad_data[2];
    assign texelOutput11 = quad_data[3];

endmodule
